// File: rtl/edge_event_arbiter.sv
// Multi-channel edge-event controller: synchronize, edge-detect, one-deep pending slot per channel,
// round-robin hand-off to a valid/ready port. Optional capture timestamps under EDGE_ARB_TIMESTAMP_EN.
module edge_event_arbiter #(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TS_W        = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [N_CH-1:0]         cin,
  input  logic [N_CH-1:0]         rise_en,
  input  logic [N_CH-1:0]         fall_en,
  input  logic [N_CH-1:0]         ovf_clr,
  output logic                    evt_valid,
  input  logic                    evt_ready,
  output logic [$clog2(N_CH)-1:0] evt_ch,
  output logic                    evt_rise,
`ifdef EDGE_ARB_TIMESTAMP_EN
  output logic [TS_W-1:0]         evt_ts,
`endif
  output logic [N_CH-1:0]         ovf
);

  localparam int CH_W  = $clog2(N_CH);
  localparam int ARM_W = $clog2(SYNC_STAGES + 2);
  // Detection compares two genuine post-release samples, so the first edge that may fire is SYNC_STAGES+2.
  localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES + 1);

  logic [N_CH-1:0] sync_p0 [SYNC_STAGES];
  logic [N_CH-1:0] sync_out;
  logic [N_CH-1:0] prev_p1;
  logic [ARM_W-1:0] arm_cnt;
  logic            armed;

  logic [N_CH-1:0] pend_p2;
  logic [N_CH-1:0] rtype_p2;
  logic [CH_W-1:0] ptr;

  logic [N_CH-1:0] chg;
  logic [N_CH-1:0] new_evt;
  logic [N_CH-1:0] acc_mask;
  logic [N_CH-1:0] free_slot;
  logic [N_CH-1:0] store;
  logic [N_CH-1:0] lost;
  logic            accept;
  logic            load;
  logic [CH_W-1:0] base;
  logic [CH_W:0]   pick;
  logic            pick_found;
  logic [CH_W-1:0] pick_ch;

  function automatic logic [CH_W-1:0] wrap_inc(input logic [CH_W-1:0] ch);
    wrap_inc = (ch == CH_W'(N_CH - 1)) ? '0 : ch + 1'b1;
  endfunction

  // Returns {found, index} of the first request at or after base, wrapping modulo N_CH.
  function automatic logic [CH_W:0] rr_pick(input logic [N_CH-1:0] req, input logic [CH_W-1:0] base_ch);
    logic [2*N_CH-1:0] rot;
    int                sum;
    rot     = {req, req} >> base_ch;
    rr_pick = '0;
    for (int off = N_CH - 1; off >= 0; off--) begin
      sum = int'(base_ch) + off;
      if (sum >= N_CH) sum = sum - N_CH;
      if (rot[off]) rr_pick = {1'b1, CH_W'(sum)};
    end
  endfunction

  assign sync_out = sync_p0[SYNC_STAGES-1];
  assign armed    = (arm_cnt == ARM_DONE);

  // Stage p0/p1: synchronizer chain and previous-level register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_p0[s] <= '0;
      prev_p1 <= '0;
      arm_cnt <= '0;
    end else begin
      sync_p0[0] <= cin;
      for (int s = 1; s < SYNC_STAGES; s++) sync_p0[s] <= sync_p0[s-1];
      prev_p1 <= sync_out;
      if (!armed) arm_cnt <= arm_cnt + 1'b1;
    end
  end

  always_comb begin
    chg     = armed ? (sync_out ^ prev_p1) : '0;
    new_evt = (chg & sync_out & rise_en) | (chg & ~sync_out & fall_en);
    accept  = evt_valid & evt_ready;
    acc_mask = '0;
    for (int i = 0; i < N_CH; i++) acc_mask[i] = accept && (evt_ch == CH_W'(i));
    free_slot  = ~pend_p2 | acc_mask;
    store      = new_evt & free_slot;
    lost       = new_evt & ~free_slot;
    load       = !evt_valid || accept;
    base       = accept ? wrap_inc(evt_ch) : ptr;
    pick       = rr_pick(pend_p2 & ~acc_mask, base);
    pick_found = pick[CH_W];
    pick_ch    = pick[CH_W-1:0];
  end

`ifdef EDGE_ARB_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt;
  logic [TS_W-1:0] ts_p2 [N_CH];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ts_cnt <= '0;
      for (int i = 0; i < N_CH; i++) ts_p2[i] <= '0;
      evt_ts <= '0;
    end else begin
      ts_cnt <= ts_cnt + 1'b1;
      for (int i = 0; i < N_CH; i++) if (store[i]) ts_p2[i] <= ts_cnt;
      if (load && pick_found) evt_ts <= ts_p2[pick_ch];
    end
  end
`endif

  // Stage p2: pending slots, overflow flags, arbiter pointer and held output
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_p2   <= '0;
      rtype_p2  <= '0;
      ovf       <= '0;
      ptr       <= '0;
      evt_valid <= 1'b0;
      evt_ch    <= '0;
      evt_rise  <= 1'b0;
    end else begin
      pend_p2 <= (pend_p2 & ~acc_mask) | store;
      for (int i = 0; i < N_CH; i++) if (store[i]) rtype_p2[i] <= sync_out[i];
      ovf <= (ovf & ~ovf_clr) | lost;
      if (accept) ptr <= wrap_inc(evt_ch);
      if (load) begin
        evt_valid <= pick_found;
        if (pick_found) begin
          evt_ch   <= pick_ch;
          evt_rise <= rtype_p2[pick_ch];
        end
      end
    end
  end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Randomized bench for edge_event_arbiter against a queue-based event model; asynchronous resets mid-run.
module tb_edge_event_arbiter;
  localparam int N_CH        = 4;
  localparam int SYNC_STAGES = 2;
  localparam int TS_W        = 4;

  logic            clk = 1'b0;
  logic            rstn;
  logic [N_CH-1:0] cin, rise_en, fall_en, ovf_clr;
  logic            evt_valid, evt_ready, evt_rise;
  logic [1:0]      evt_ch;
  logic [N_CH-1:0] ovf;
`ifdef EDGE_ARB_TIMESTAMP_EN
  logic [TS_W-1:0] evt_ts;
`endif

  always #5 clk = ~clk;

  edge_event_arbiter #(.N_CH(N_CH), .SYNC_STAGES(SYNC_STAGES), .TS_W(TS_W)) dut (
    .clk(clk), .rstn(rstn), .cin(cin), .rise_en(rise_en), .fall_en(fall_en),
    .ovf_clr(ovf_clr), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_ch(evt_ch), .evt_rise(evt_rise),
`ifdef EDGE_ARB_TIMESTAMP_EN
    .evt_ts(evt_ts),
`endif
    .ovf(ovf)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: history of sampled inputs, per-channel slots, held presentation.
  logic [N_CH-1:0] samp [$];
  int              m_k, m_ptr, m_ch, m_tsc;
  bit              m_valid, m_rise;
  int              m_ts;
  bit              m_pend [N_CH];
  bit              m_type [N_CH];
  int              m_tsv  [N_CH];
  logic [N_CH-1:0] m_ovf;

  task automatic model_reset();
    samp.delete();
    m_k = 0; m_ptr = 0; m_ch = 0; m_tsc = 0; m_ts = 0;
    m_valid = 0; m_rise = 0; m_ovf = '0;
    for (int i = 0; i < N_CH; i++) begin m_pend[i] = 0; m_type[i] = 0; m_tsv[i] = 0; end
  endtask

  task automatic model_step();
    bit acc, found;
    int ac, base, g;
    logic [N_CH-1:0] s_new, s_old;
    bit nev [N_CH];
    bit nrise [N_CH];
    acc = m_valid && evt_ready;
    ac  = m_ch;
    samp.push_front(cin);
    if (samp.size() > SYNC_STAGES + 2) void'(samp.pop_back());
    m_k++;
    for (int i = 0; i < N_CH; i++) begin nev[i] = 0; nrise[i] = 0; end
    if (m_k >= SYNC_STAGES + 2) begin
      s_new = samp[SYNC_STAGES];
      s_old = samp[SYNC_STAGES+1];
      for (int i = 0; i < N_CH; i++)
        if (s_new[i] != s_old[i]) begin
          nrise[i] = s_new[i];
          nev[i]   = s_new[i] ? rise_en[i] : fall_en[i];
        end
    end
    if (!m_valid || acc) begin
      base = acc ? (ac + 1) % N_CH : m_ptr;
      found = 0; g = 0;
      for (int off = 0; off < N_CH && !found; off++) begin
        g = (base + off) % N_CH;
        if (m_pend[g] && !(acc && g == ac)) found = 1;
      end
      m_valid = found;
      if (found) begin m_ch = g; m_rise = m_type[g]; m_ts = m_tsv[g]; end
    end
    if (acc) begin m_ptr = (ac + 1) % N_CH; m_pend[ac] = 0; end
    for (int i = 0; i < N_CH; i++) if (ovf_clr[i]) m_ovf[i] = 1'b0;
    for (int i = 0; i < N_CH; i++)
      if (nev[i]) begin
        if (!m_pend[i]) begin m_pend[i] = 1; m_type[i] = nrise[i]; m_tsv[i] = m_tsc; end
        else m_ovf[i] = 1'b1;
      end
    m_tsc = (m_tsc + 1) % (1 << TS_W);
  endtask

  always @(posedge clk or negedge rstn) begin
    if (!rstn) model_reset();
    else       model_step();
  end

  task automatic check_outputs();
    chk("evt_valid", evt_valid, m_valid);
    chk("evt_ch", evt_ch, m_ch);
    chk("evt_rise", evt_rise, m_rise);
    chk("ovf", ovf, m_ovf);
`ifdef EDGE_ARB_TIMESTAMP_EN
    chk("evt_ts", evt_ts, m_ts);
`endif
  endtask

  task automatic do_async_reset();
    #2 rstn = 1'b0;
    #1;
    chk("rst_valid", evt_valid, 0);
    chk("rst_ch", evt_ch, 0);
    chk("rst_rise", evt_rise, 0);
    chk("rst_ovf", ovf, 0);
`ifdef EDGE_ARB_TIMESTAMP_EN
    chk("rst_ts", evt_ts, 0);
`endif
    @(negedge clk);
    cin  = N_CH'($urandom);
    rstn = 1'b1;
  endtask

  task automatic drive(input int phase);
    int flip_thr, rdy_thr;
    case (phase)
      0: begin flip_thr = 1;  rdy_thr = 16; end
      1: begin flip_thr = 4;  rdy_thr = 8;  end
      2: begin flip_thr = 8;  rdy_thr = 2;  end
      default: begin flip_thr = 2; rdy_thr = 14; end
    endcase
    for (int i = 0; i < N_CH; i++) if ($urandom_range(0, 15) < flip_thr) cin[i] = ~cin[i];
    evt_ready = ($urandom_range(0, 15) < rdy_thr);
    ovf_clr   = ($urandom_range(0, 7) == 0) ? N_CH'($urandom) : '0;
    if ($urandom_range(0, 63) == 0) begin
      rise_en = ($urandom_range(0, 1) == 0) ? '1 : N_CH'($urandom);
      fall_en = ($urandom_range(0, 1) == 0) ? '1 : N_CH'($urandom);
    end
  endtask

  initial begin
    rstn = 1'b0; cin = '0; rise_en = '1; fall_en = '1; ovf_clr = '0; evt_ready = 1'b1;
    #1;
    chk("init_valid", evt_valid, 0);
    chk("init_ovf", ovf, 0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(negedge clk);
      check_outputs();
      if (cyc == 8) cin[0] = 1'b1;
      else if (cyc < 20) ;
      else if (cyc % 500 == 250) do_async_reset();
      else drive((cyc / 200) % 4);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
